// File: rtl/multi_cycle_sequencer_if.sv
// Memory-side handshake bundle for multi_cycle_sequencer.
// Covers the instruction-fetch and data-access request/ack pairs.
`default_nettype none

interface multi_cycle_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic              dmem_req;
   logic              dmem_we;
   logic              dmem_ack;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we,
      input  imem_ack, imem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we,
      output imem_ack, imem_rdata, dmem_ack
   );
endinterface

`default_nettype wire

// File: rtl/multi_cycle_sequencer.sv
// PC / phase sequencer for the multi-cycle core: owns pc, instr and the
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK FSM with req/ack memory handshakes.
`default_nettype none

module multi_cycle_sequencer #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1),
   parameter int                CNT_W    = 32,
   parameter int                TIMEOUT  = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   multi_cycle_sequencer_if.master     mem,
   output logic [DATA_W-1:0]           instr,
   input  logic                        dec_load,
   input  logic                        dec_store,
   input  logic                        dec_reg_write,
   input  logic                        dec_halt,
   input  logic                        br_taken,
   input  logic [ADDR_W-1:0]           br_target,
   output logic                        alu_en,
   output logic                        rf_we,
   output logic [ADDR_W-1:0]           pc,
   output logic [ADDR_W-1:0]           pc_link,
   output logic                        retire,
   output logic [CNT_W-1:0]            retired,
   output logic                        halted,
   output logic                        bus_err
);

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEMORY    = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5
   } state_t;

   localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t              state;
   state_t              state_next;
   logic [ADDR_W-1:0]   next_pc_q;
   logic [ADDR_W-1:0]   exec_pc;
   logic [ADDR_W-1:0]   retire_pc;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                wait_expired;
   logic                timeout_hit;

   assign exec_pc      = br_taken ? br_target : pc + PC_STEP;
   // A direct EXECUTE->FETCH retire has not latched next_pc yet, so bypass it.
   assign retire_pc    = (state == ST_EXECUTE) ? exec_pc : next_pc_q;
   assign wait_expired = (TIMEOUT > 0) && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      timeout_hit = 1'b0;
      case (state)
         ST_FETCH: begin
            if (mem.imem_ack) begin
               state_next = ST_DECODE;
            end else if (wait_expired) begin
               state_next  = ST_HALT;
               timeout_hit = 1'b1;
            end
         end
         ST_DECODE: begin
            state_next = dec_halt ? ST_HALT : ST_EXECUTE;
         end
         ST_EXECUTE: begin
            if (dec_load || dec_store) begin
               state_next = ST_MEMORY;
            end else if (dec_reg_write) begin
               state_next = ST_WRITEBACK;
            end else begin
               state_next = ST_FETCH;
            end
         end
         ST_MEMORY: begin
            if (mem.dmem_ack) begin
               state_next = dec_load ? ST_WRITEBACK : ST_FETCH;
            end else if (wait_expired) begin
               state_next  = ST_HALT;
               timeout_hit = 1'b1;
            end
         end
         ST_WRITEBACK: state_next = ST_FETCH;
         ST_HALT:      state_next = ST_HALT;
         default:      state_next = ST_FETCH;
      endcase
   end

   assign retire = (state_next == ST_FETCH) &&
                   ((state == ST_EXECUTE) || (state == ST_MEMORY) || (state == ST_WRITEBACK));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc        <= RESET_PC;
         next_pc_q <= RESET_PC;
         instr     <= '0;
         retired   <= '0;
         bus_err   <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         if ((state == ST_FETCH) && mem.imem_ack) begin
            instr <= mem.imem_rdata;
         end
         if (state == ST_EXECUTE) begin
            next_pc_q <= exec_pc;
         end
         if (retire) begin
            pc      <= retire_pc;
            retired <= retired + CNT_W'(1);
         end
         if (timeout_hit) begin
            bus_err <= 1'b1;
         end
         if (state_next != state) begin
            wait_cnt <= '0;
         end else if ((state == ST_FETCH) || (state == ST_MEMORY)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
      end
   end

   // Requests and strobes are also masked by reset so they drop the instant it asserts.
   assign mem.imem_req  = reset && (state == ST_FETCH);
   assign mem.imem_addr = pc;
   assign mem.dmem_req  = reset && (state == ST_MEMORY);
   assign mem.dmem_we   = reset && (state == ST_MEMORY) && dec_store;
   assign alu_en        = reset && (state == ST_EXECUTE);
   assign rf_we         = reset && (state == ST_WRITEBACK);
   assign pc_link       = pc + PC_STEP;
   assign halted        = (state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_sequencer.sv
// Self-checking bench for multi_cycle_sequencer: directed and random instructions
// checked against a latency/PC model derived from the instruction class.
`default_nettype none

module tb_multi_cycle_sequencer;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int CW = 32;
   localparam int TO = 8;

   logic          clk   = 1'b0;
   logic          reset = 1'b0;
   logic          dec_load = 1'b0, dec_store = 1'b0, dec_reg_write = 1'b0, dec_halt = 1'b0;
   logic          br_taken = 1'b0;
   logic [AW-1:0] br_target = '0;
   logic [DW-1:0] instr;
   logic          alu_en, rf_we, retire, halted, bus_err;
   logic [AW-1:0] pc, pc_link;
   logic [CW-1:0] retired;

   int n_checks = 0;
   int n_err    = 0;

   logic [AW-1:0] m_pc  = '0;
   int unsigned   m_ret = 0;

   typedef struct {
      int            cyc, alu_at, n_alu, n_rf, rf_at, n_dreq, n_dwe, n_ret;
      logic [AW-1:0] first_addr, link;
      logic [DW-1:0] word;
   } obs_t;

   always #5 clk = ~clk;

   multi_cycle_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

   multi_cycle_sequencer #(
      .ADDR_W(AW), .DATA_W(DW), .RESET_PC(32'h0), .PC_STEP(32'h1),
      .CNT_W(CW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset), .mem(mif.master), .instr(instr),
      .dec_load(dec_load), .dec_store(dec_store), .dec_reg_write(dec_reg_write),
      .dec_halt(dec_halt), .br_taken(br_taken), .br_target(br_target),
      .alu_en(alu_en), .rf_we(rf_we), .pc(pc), .pc_link(pc_link),
      .retire(retire), .retired(retired), .halted(halted), .bus_err(bus_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Assert reset for a few cycles (checking the cleared state), then release it
   // one time unit after a rising edge so the next edge closes the first FETCH cycle.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      mif.imem_ack = 1'b0;
      mif.dmem_ack = 1'b0;
      #1;
      check({tag, ".imem_req_in_reset"}, mif.imem_req, 1'b0);
      check({tag, ".dmem_req_in_reset"}, mif.dmem_req, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check({tag, ".pc"},      pc,      0);
      check({tag, ".retired"}, retired, 0);
      check({tag, ".instr"},   instr,   0);
      check({tag, ".halted"},  halted,  1'b0);
      check({tag, ".bus_err"}, bus_err, 1'b0);
      check({tag, ".retire"},  retire,  1'b0);
      reset    = 1'b1;
      dec_halt = 1'b0;
      m_pc     = '0;
      m_ret    = 0;
      #1;
      check({tag, ".imem_req_after"},  mif.imem_req,  1'b1);
      check({tag, ".imem_addr_after"}, mif.imem_addr, 0);
   endtask

   // Drives one instruction from its FETCH cycle until retire (or halt), with
   // iw fetch wait cycles and dw data wait cycles. Entered at posedge+1.
   task automatic run_instr(input int iw, input int dw, output obs_t o);
      int ic = 0;
      int dc = 0;
      o = '{default: 0};
      o.first_addr = mif.imem_addr;
      for (int c = 1; c <= 64; c++) begin
         mif.imem_rdata = DW'($urandom);
         mif.imem_ack   = mif.imem_req && (ic == iw);
         mif.dmem_ack   = mif.dmem_req && (dc == dw);
         if (mif.imem_ack) o.word = mif.imem_rdata;
         @(negedge clk);
         if (mif.imem_req) ic++;
         if (mif.dmem_req) begin
            dc++;
            if (mif.dmem_we) o.n_dwe++;
         end
         if (alu_en) begin
            o.n_alu++;
            o.alu_at = c;
            o.link   = pc_link;
         end
         if (rf_we) begin
            o.n_rf++;
            o.rf_at = c;
         end
         if (retire) o.n_ret++;
         o.n_dreq = dc;
         o.cyc    = c;
         @(posedge clk);
         #1;
         mif.imem_ack = 1'b0;
         mif.dmem_ack = 1'b0;
         if (o.n_ret != 0 || halted) break;
      end
   endtask

   // cls: 0 alu, 1 load, 2 store, 3 branch (tk decides), 4 nop, 5 jal
   task automatic do_instr(input string tag, input int cls, input int iw, input int dw,
                           input logic tk, input logic [AW-1:0] tgt);
      obs_t o;
      obs_t e;
      logic ld, st, wr, tkn;
      int   f, memc, wb;
      ld  = (cls == 1);
      st  = (cls == 2);
      wr  = (cls == 0) || (cls == 1) || (cls == 5);
      tkn = (cls == 5) || ((cls == 3) && tk);
      dec_load = ld; dec_store = st; dec_reg_write = wr; dec_halt = 1'b0;
      br_taken = tkn; br_target = tgt;

      e      = '{default: 0};
      f      = iw + 1;
      memc   = (ld || st) ? dw + 1 : 0;
      wb     = (ld || (!st && wr)) ? 1 : 0;
      e.cyc  = f + 2 + memc + wb;
      e.alu_at = f + 2;
      e.n_rf   = wb;
      e.rf_at  = (wb != 0) ? e.cyc : 0;
      e.n_dreq = memc;
      e.n_dwe  = st ? memc : 0;
      e.link   = m_pc + 1;

      run_instr(iw, dw, o);

      check({tag, ".cycles"},    o.cyc,        e.cyc);
      check({tag, ".alu_cycle"}, o.alu_at,     e.alu_at);
      check({tag, ".alu_count"}, o.n_alu,      1);
      check({tag, ".rf_count"},  o.n_rf,       e.n_rf);
      check({tag, ".rf_cycle"},  o.rf_at,      e.rf_at);
      check({tag, ".dreq"},      o.n_dreq,     e.n_dreq);
      check({tag, ".dwe"},       o.n_dwe,      e.n_dwe);
      check({tag, ".retires"},   o.n_ret,      1);
      check({tag, ".fetch_addr"}, o.first_addr, m_pc);
      check({tag, ".pc_link"},   o.link,       e.link);
      m_pc = tkn ? tgt : m_pc + 1;
      m_ret++;
      check({tag, ".pc"},        pc,           m_pc);
      check({tag, ".imem_addr"}, mif.imem_addr, m_pc);
      check({tag, ".retired"},   retired,      CW'(m_ret));
      check({tag, ".instr"},     instr,        o.word);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      obs_t o;
      int   n;
      bit   seen;
      mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0; mif.imem_rdata = '0;
      @(posedge clk);
      do_reset("rst0");

      do_instr("alu",    0, 0, 0, 1'b0, '0);
      do_instr("load_w2", 1, 0, 2, 1'b0, '0);
      do_instr("store",  2, 0, 0, 1'b0, '0);
      do_instr("branch", 3, 0, 0, 1'b1, 32'h40);
      do_instr("jal",    5, 1, 0, 1'b0, 32'h100);
      do_instr("nop",    4, 0, 0, 1'b0, '0);

      for (int i = 0; i < 24; i++) begin
         do_instr($sformatf("rnd%0d", i), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), AW'($urandom));
      end

      do_instr("wrap_br",  3, 0, 0, 1'b1, 32'hFFFF_FFFF);
      do_instr("wrap_alu", 0, 0, 0, 1'b0, '0);
      check("wrap.pc_zero", pc, 0);

      // Halt in DECODE: pc and retired stay put, requests stop.
      dec_load = 1'b0; dec_store = 1'b0; dec_reg_write = 1'b0; br_taken = 1'b0;
      dec_halt = 1'b1;
      run_instr(0, 0, o);
      check("halt.cycles",  o.cyc,   2);
      check("halt.alu",     o.n_alu, 0);
      check("halt.retires", o.n_ret, 0);
      repeat (3) begin
         mif.imem_ack = 1'b1; mif.dmem_ack = 1'b1;
         @(posedge clk);
         #1;
      end
      mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0;
      check("halt.halted",   halted,       1'b1);
      check("halt.pc",       pc,           m_pc);
      check("halt.retired",  retired,      CW'(m_ret));
      check("halt.imem_req", mif.imem_req, 1'b0);
      check("halt.bus_err",  bus_err,      1'b0);
      do_reset("rst_halt");

      // Reset pulse while a load waits in MEMORY.
      dec_load = 1'b1; dec_reg_write = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         mif.imem_ack = mif.imem_req;
         mif.dmem_ack = 1'b0;
         if (mif.dmem_req) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      check("memrst.reached", seen, 1'b1);
      mif.imem_ack = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("memrst.dmem_req", mif.dmem_req, 1'b0);
      check("memrst.imem_req", mif.imem_req, 1'b0);
      check("memrst.rf_we",    rf_we,        1'b0);
      check("memrst.pc",       pc,           0);
      do_reset("rst_mem");
      do_instr("post_rst", 0, 0, 0, 1'b0, '0);

      // Fetch timeout: imem_ack never arrives.
      dec_load = 1'b0; dec_store = 1'b0; dec_reg_write = 1'b1;
      mif.imem_ack = 1'b0;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mif.imem_req) n++;
         @(posedge clk);
         #1;
         if (halted) break;
      end
      check("to.req_cycles", n,            TO);
      check("to.bus_err",    bus_err,      1'b1);
      check("to.halted",     halted,       1'b1);
      check("to.imem_req",   mif.imem_req, 1'b0);
      check("to.pc",         pc,           m_pc);
      do_reset("rst_to");
      do_instr("after_to", 4, 0, 0, 1'b0, '0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/multi_cycle_sequencer.md
# multi_cycle_sequencer

Parametrised PC/phase sequencer for the next-generation multi-cycle RISC core, replacing the single-cycle top's one-instruction-per-clock flow. It owns the program counter, instruction register and phase FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK). It runs variable-latency req/ack handshakes to instruction and data memory and issues one-cycle enable strobes to the ALU and register file. Decode and branch evaluation stay in the existing control and branch units, which feed this block combinationally.

## Interface
- ADDR_W, 32, PC/address width
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value after reset
- PC_STEP, 1, PC increment; memory is word-addressed
- CNT_W, 32, retired-instruction counter width
- TIMEOUT, 0, max wait cycles per memory request; 0 disables the timeout

- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  fetch address; equals pc
- imem_ack  in  1  fetch complete; imem_rdata valid
- imem_rdata  in  DATA_W  fetched instruction
- instr  out  DATA_W  instruction register
- dec_load, dec_store, dec_reg_write, dec_halt  in  1 each  decode flags for instr
- br_taken  in  1  branch/jump taken; sampled in EXECUTE
- br_target  in  ADDR_W  redirect address; sampled in EXECUTE
- alu_en  out  1  EXECUTE strobe
- dmem_req  out  1  data request
- dmem_we  out  1  write qualifier; equals dec_store while dmem_req is high
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write strobe
- pc  out  ADDR_W  current PC
- pc_link  out  ADDR_W  pc + PC_STEP, used as link data
- retire  out  1  one-cycle pulse per completed instruction
- retired  out  CNT_W  count of completed instructions
- halted  out  1  sequencer stopped
- bus_err  out  1  memory timeout occurred

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- FETCH
  - imem_req is high.
  - On imem_ack: instr <= imem_rdata, then go to DECODE.
- DECODE
  - One cycle.
  - If dec_halt: go to HALT and leave pc unchanged.
  - Otherwise go to EXECUTE.
- EXECUTE
  - alu_en is high for one cycle.
  - Latch next_pc: br_target if br_taken, else pc + PC_STEP (mod 2^ADDR_W).
  - Next state: MEMORY if dec_load or dec_store; else WRITEBACK if dec_reg_write; else FETCH.
- MEMORY
  - dmem_req is high; dmem_we = dec_store.
  - On dmem_ack: go to WRITEBACK if dec_load, else FETCH.
- WRITEBACK
  - rf_we is high for one cycle, then go to FETCH.
- Retirement (every transition into FETCH)
  - pc <= next_pc.
  - retire pulses.
  - retired increments and wraps at 2^CNT_W.
- HALT
  - Absorbing until reset; all requests and strobes are 0; halted = 1.
- Strobes and requests are decoded combinationally from state only.
- Acks are ignored when the matching request is low.
- Timeout (TIMEOUT > 0)
  - A wait counter clears on entry to FETCH or MEMORY and increments each request cycle without ack.
  - When it reaches TIMEOUT with no ack: bus_err <= 1 and go to HALT.
  - An ack arriving in the same cycle as the limit wins.

## Timing
- Reset values: state = FETCH, pc = RESET_PC, instr = 0, retired = 0, halted = 0, bus_err = 0, retire = 0.
  - imem_req is therefore high immediately after reset deasserts.
- Reset asserted mid-operation immediately (asynchronously) drops dmem_req/imem_req/rf_we and restarts from RESET_PC.
- An ack in the same cycle as its request counts (zero-wait).
- Latency with zero-wait memory:
  - ALU/reg-write and jal: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch or nop: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- br_taken, br_target and dec_* must be stable from DECODE through the end of the instruction; instr does not change until the next FETCH ack.
- The pc output changes only on the retire edge. imem_addr for the next fetch is valid in the cycle after retire.
- PC wraps silently from 2^ADDR_W - PC_STEP to 0.

## Test plan
- Reset then ALU instruction (dec_reg_write = 1, imem_ack tied 1) -> states F, D, E, W; alu_en in cycle 3; rf_we in cycle 4; retire in cycle 4; pc 0 -> 1; retired = 1.
- Load with dmem_ack delayed 2 cycles -> dmem_req high 3 cycles; dmem_we = 0; rf_we 1 cycle after ack; 7 cycles total; pc += 1.
- Store, zero-wait -> dmem_we = 1 with dmem_req for 1 cycle; no rf_we; 4 cycles.
- Branch with br_taken = 1, br_target = 0x40 -> no rf_we; next imem_addr = 0x40; pc_link = old pc + 1 during EXECUTE.
- TIMEOUT = 8, imem_ack held 0 -> imem_req high 8 cycles; then bus_err = 1, halted = 1, imem_req = 0. Asserting reset clears all, and fetch restarts at RESET_PC.
- dec_halt in DECODE -> halted = 1 and pc unchanged. Separately: reset pulse mid-MEMORY drops dmem_req the same cycle. Separately: pc = 0xFFFFFFFF retiring a non-branch -> pc = 0.
